// File: rtl/xif_copro_pkg.sv
// Shared types for the CV-X-IF coprocessor tracker: decode constants, entry state and entry record.
// Optional MUL support is enabled by defining XIF_COPRO_MUL_EN.
package xif_copro_pkg;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_XOR  = 3'b001;
    localparam logic [2:0] F3_MAXU = 3'b010;
    localparam logic [2:0] F3_MUL  = 3'b011;

    // Field widths of the stored entry; the tracker parameters must match these.
    localparam int ENTRY_ID_W  = 4;
    localparam int ENTRY_RFR_W = 32;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        WAIT   = 2'd1,
        READY  = 2'd2,
        KILLED = 2'd3
    } entry_state_e;

    typedef struct packed {
        logic [ENTRY_ID_W-1:0]  id;
        logic [2:0]             funct3;
        logic [4:0]             rd;
        logic [ENTRY_RFR_W-1:0] rs1;
        logic [ENTRY_RFR_W-1:0] rs2;
        logic                   ops;
        logic                   cmt;
        entry_state_e           state;
    } entry_t;

    function automatic logic is_supported(input logic [2:0] f3);
        case (f3)
            F3_ADD, F3_XOR, F3_MAXU: return 1'b1;
`ifdef XIF_COPRO_MUL_EN
            F3_MUL: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/xif_copro_tracker_if.sv
// CV-X-IF issue/register/commit/result channels between the host core (master) and the coprocessor (slave).
// Handshake: a transfer happens on a rising edge where valid and ready are both high; issue and register responses are combinational in that cycle.
interface xif_copro_tracker_if #(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFR_WIDTH = 32
) ();

    logic                     issue_valid_i;
    logic                     issue_ready_o;
    logic [31:0]              issue_instr_i;
    logic [X_ID_WIDTH-1:0]    issue_id_i;
    logic                     issue_accept_o;
    logic                     issue_writeback_o;
    logic [1:0]               issue_register_read_o;

    logic                     register_valid_i;
    logic                     register_ready_o;
    logic [X_ID_WIDTH-1:0]    register_id_i;
    logic [2*X_RFR_WIDTH-1:0] register_rs_i;
    logic [1:0]               register_rs_valid_i;

    logic                     commit_valid_i;
    logic [X_ID_WIDTH-1:0]    commit_id_i;
    logic                     commit_kill_i;

    logic                     result_valid_o;
    logic                     result_ready_i;
    logic [X_ID_WIDTH-1:0]    result_id_o;
    logic [X_RFR_WIDTH-1:0]   result_data_o;
    logic [4:0]               result_rd_o;
    logic                     result_we_o;

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i,
        output issue_ready_o, issue_accept_o, issue_writeback_o, issue_register_read_o,
        input  register_valid_i, register_id_i, register_rs_i, register_rs_valid_i,
        output register_ready_o,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
        input  result_ready_i
    );

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i,
        input  issue_ready_o, issue_accept_o, issue_writeback_o, issue_register_read_o,
        output register_valid_i, register_id_i, register_rs_i, register_rs_valid_i,
        input  register_ready_o,
        output commit_valid_i, commit_id_i, commit_kill_i,
        input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
        output result_ready_i
    );

endinterface

// File: rtl/xif_copro_alu.sv
// Combinational custom-0 ALU: ADD, XOR, MAXU, and MUL (low half) when XIF_COPRO_MUL_EN is defined.
module xif_copro_alu
    import xif_copro_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]   funct3,
    input  logic [W-1:0] rs1,
    input  logic [W-1:0] rs2,
    output logic [W-1:0] data
);

    always_comb begin
        data = '0;
        case (funct3)
            F3_ADD:  data = rs1 + rs2;
            F3_XOR:  data = rs1 ^ rs2;
            F3_MAXU: data = (rs1 > rs2) ? rs1 : rs2;
`ifdef XIF_COPRO_MUL_EN
            F3_MUL:  data = rs1 * rs2;
`endif
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/xif_copro_tracker.sv
// CV-X-IF coprocessor endpoint: in-order table of offloaded custom-0 ALU ops, results returned in issue order.
// Define XIF_COPRO_MUL_EN to also accept and execute MUL (funct3=011).
module xif_copro_tracker
    import xif_copro_pkg::*;
#(
    parameter int X_ID_WIDTH  = ENTRY_ID_W,
    parameter int X_RFR_WIDTH = ENTRY_RFR_W,
    parameter int DEPTH       = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    xif_copro_tracker_if.slave  xif,
    output entry_state_e        dbg_head_state
);

    localparam int PW = $clog2(DEPTH);

    entry_t        tbl_q [DEPTH];
    entry_t        tbl_d [DEPTH];
    entry_t        head_e;
    logic [PW-1:0] head_q, tail_q;
    logic [PW:0]   count_q;

    logic [2:0]  issue_f3;
    logic        full, push, pop, load;
    logic        reg_hit, cmt_hit, dup_hit, reg_take, cmt_take;
    logic [PW-1:0] reg_idx, cmt_idx;
    logic [16:0] unused_instr;

    logic                   res_valid_q;
    logic [X_ID_WIDTH-1:0]  res_id_q;
    logic [X_RFR_WIDTH-1:0] res_data_q, alu_data;
    logic [4:0]             res_rd_q;

    assign issue_f3     = xif.issue_instr_i[14:12];
    assign unused_instr = xif.issue_instr_i[31:15];
    assign full         = (count_q == (PW+1)'(DEPTH));

    // Issue response is combinational; a reject leaves every response field low.
    assign xif.issue_ready_o         = !full;
    assign push                      = xif.issue_valid_i && !full &&
                                       (xif.issue_instr_i[6:0] == OPCODE_CUSTOM0) && is_supported(issue_f3);
    assign xif.issue_accept_o        = push;
    assign xif.issue_writeback_o     = push;
    assign xif.issue_register_read_o = {push, push};

    always_comb begin
        reg_hit = 1'b0;
        reg_idx = '0;
        cmt_hit = 1'b0;
        cmt_idx = '0;
        dup_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tbl_q[i].state != FREE) begin
                if (tbl_q[i].id == xif.register_id_i) begin
                    reg_hit = 1'b1;
                    reg_idx = PW'(i);
                end
                if (tbl_q[i].id == xif.commit_id_i) begin
                    cmt_hit = 1'b1;
                    cmt_idx = PW'(i);
                end
                if (tbl_q[i].id == xif.issue_id_i) dup_hit = 1'b1;
            end
        end
    end

    // Partial operands for a tracked id are stalled; unknown ids are consumed and dropped.
    assign xif.register_ready_o = xif.register_valid_i && (!reg_hit || xif.register_rs_valid_i == 2'b11);
    assign reg_take = xif.register_valid_i && reg_hit && (xif.register_rs_valid_i == 2'b11);
    assign cmt_take = xif.commit_valid_i && cmt_hit;

    always_comb begin
        tbl_d = tbl_q;
        if (reg_take) begin
            tbl_d[reg_idx].rs1 = xif.register_rs_i[X_RFR_WIDTH-1:0];
            tbl_d[reg_idx].rs2 = xif.register_rs_i[2*X_RFR_WIDTH-1:X_RFR_WIDTH];
            tbl_d[reg_idx].ops = 1'b1;
        end
        if (cmt_take) begin
            if (xif.commit_kill_i) tbl_d[cmt_idx].state = KILLED;
            else                   tbl_d[cmt_idx].cmt   = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (tbl_d[i].state == WAIT && tbl_d[i].ops && tbl_d[i].cmt) tbl_d[i].state = READY;
        end
        // The head is judged on this cycle's updates so a READY head reaches the output one edge later.
        head_e = tbl_d[head_q];
        load   = (head_e.state == READY) && (!res_valid_q || xif.result_ready_i);
        pop    = (head_e.state == KILLED) || load;
        if (pop) tbl_d[head_q].state = FREE;
        if (push) begin
            tbl_d[tail_q] = '{id: xif.issue_id_i, funct3: issue_f3, rd: xif.issue_instr_i[11:7],
                              rs1: '0, rs2: '0, ops: 1'b0, cmt: 1'b0, state: WAIT};
        end
    end

    xif_copro_alu #(.W(X_RFR_WIDTH)) u_alu (
        .funct3 (head_e.funct3),
        .rs1    (head_e.rs1),
        .rs2    (head_e.rs2),
        .data   (alu_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
        end else begin
            tbl_q   <= tbl_d;
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            if (load) begin
                res_valid_q <= 1'b1;
                res_id_q    <= head_e.id;
                res_data_q  <= alu_data;
                res_rd_q    <= head_e.rd;
            end else if (xif.result_ready_i) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) assert (!dup_hit);
    end

    assign xif.result_valid_o = res_valid_q;
    assign xif.result_id_o    = res_id_q;
    assign xif.result_data_o  = res_data_q;
    assign xif.result_rd_o    = res_rd_q;
    assign xif.result_we_o    = res_valid_q;
    assign dbg_head_state     = tbl_q[head_q].state;

endmodule

// File: tb/tb_xif_copro_tracker.sv
// Bench for xif_copro_tracker: directed scenarios plus randomized rounds scored against an in-order result queue.
module tb_xif_copro_tracker;
  import xif_copro_pkg::*;

  localparam int IDW   = 4;
  localparam int RW    = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  entry_state_e dbg_head_state;
  int           n_checks = 0;
  int           n_fail = 0;
  int           rr_mode = 0;
  logic [40:0]  exp_q[$];
  logic [40:0]  cur, stall_val;
  logic         stall_seen;

  xif_copro_tracker_if #(.X_ID_WIDTH(IDW), .X_RFR_WIDTH(RW)) xif ();

  xif_copro_tracker #(.X_ID_WIDTH(IDW), .X_RFR_WIDTH(RW), .DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .xif            (xif),
    .dbg_head_state (dbg_head_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference rules
  function automatic logic acc_ref(input logic [31:0] instr);
    logic [2:0] f3;
    f3 = instr[14:12];
    if (instr[6:0] != 7'b0001011) return 1'b0;
`ifdef XIF_COPRO_MUL_EN
    return f3 <= 3'd3;
`else
    return f3 <= 3'd2;
`endif
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint unsigned s;
    case (f3)
      3'd0: begin s = longint'(a) + longint'(b); return s[31:0]; end
      3'd1: return a ^ b;
      3'd2: return (a > b) ? a : b;
      default: begin s = longint'(a) * longint'(b); return s[31:0]; end
    endcase
  endfunction

  function automatic logic [31:0] mk_instr(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    logic [16:0] hi;
    hi = 17'($urandom);
    return {hi, f3, rd, op};
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // Result ready driver
  initial begin
    xif.result_ready_i = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rr_mode)
        0: xif.result_ready_i = 1'b1;
        1: xif.result_ready_i = ($urandom_range(0, 3) != 0);
        default: xif.result_ready_i = 1'b0;
      endcase
    end
  end

  // Result scoreboard and hold check
  always @(negedge clk) begin
    if (rst) begin
      stall_seen <= 1'b0;
    end else begin
      cur = {xif.result_id_o, xif.result_rd_o, xif.result_data_o};
      if (stall_seen) check_eq("result_hold", {xif.result_valid_o, cur}, {1'b1, stall_val});
      if (xif.result_valid_o) begin
        check_eq("result_we", xif.result_we_o, 1'b1);
        if (xif.result_ready_i) begin
          if (exp_q.size() == 0) check_eq("unexpected_result", xif.result_valid_o, 1'b0);
          else check_eq("result_fields", cur, exp_q.pop_front());
        end
      end
      stall_seen <= xif.result_valid_o && !xif.result_ready_i;
      stall_val  <= cur;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk); #1;
    xif.issue_valid_i    = 1'b0;
    xif.register_valid_i = 1'b0;
    xif.commit_valid_i   = 1'b0;
  endtask

  task automatic do_issue(input logic [3:0] id, input logic [31:0] instr, input logic exp_acc);
    cyc();
    xif.issue_valid_i = 1'b1;
    xif.issue_id_i    = id;
    xif.issue_instr_i = instr;
    @(negedge clk);
    check_eq("issue_ready", xif.issue_ready_o, 1'b1);
    check_eq("issue_accept", xif.issue_accept_o, exp_acc);
    check_eq("issue_writeback", xif.issue_writeback_o, exp_acc);
    check_eq("issue_register_read", xif.issue_register_read_o, {exp_acc, exp_acc});
  endtask

  task automatic reg_op(input logic [3:0] id, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] vld, input logic exp_rdy);
    cyc();
    xif.register_valid_i    = 1'b1;
    xif.register_id_i       = id;
    xif.register_rs_i       = {b, a};
    xif.register_rs_valid_i = vld;
    @(negedge clk);
    check_eq("register_ready", xif.register_ready_o, exp_rdy);
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    cyc();
    xif.commit_valid_i = 1'b1;
    xif.commit_id_i    = id;
    xif.commit_kill_i  = kill;
    @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      cyc();
      guard++;
    end
    check_eq("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    rr_mode = 0;
    repeat (6) cyc();
    @(negedge clk);
    check_eq("drain_head_free", dbg_head_state, FREE);
    check_eq("drain_result_idle", xif.result_valid_o, 1'b0);
    check_eq("drain_issue_ready", xif.issue_ready_o, 1'b1);
  endtask

  logic [3:0]  r_id[4];
  logic [31:0] r_ins[4], r_a[4], r_b[4];
  logic        r_acc[4], r_kill[4], r_dead[4];
  int          act[8];
  int          n, n2, start, j, tmp, e;

  initial begin
    rst = 1'b1;
    xif.issue_valid_i = 1'b0; xif.issue_instr_i = '0; xif.issue_id_i = '0;
    xif.register_valid_i = 1'b0; xif.register_id_i = '0; xif.register_rs_i = '0;
    xif.register_rs_valid_i = '0;
    xif.commit_valid_i = 1'b0; xif.commit_id_i = '0; xif.commit_kill_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_issue_ready", xif.issue_ready_o, 1'b1);
    check_eq("reset_result_valid", xif.result_valid_o, 1'b0);
    check_eq("reset_register_ready", xif.register_ready_o, 1'b0);
    check_eq("reset_head_state", dbg_head_state, FREE);
    cyc();
    rst = 1'b0;

    // ADD with single-cycle result latency
    do_issue(4'd3, mk_instr(OPCODE_CUSTOM0, F3_ADD, 5'd5), 1'b1);
    reg_op(4'd3, 32'd7, 32'd9, 2'b11, 1'b1);
    exp_q.push_back({4'd3, 5'd5, 32'd16});
    commit(4'd3, 1'b0);
    cyc();
    @(negedge clk);
    check_eq("add_latency", xif.result_valid_o, 1'b1);
    drain();

    // Rejected opcode: commit and operands for its id have no effect
    do_issue(4'd6, mk_instr(7'b0110011, F3_ADD, 5'd1), 1'b0);
    reg_op(4'd6, 32'd1, 32'd2, 2'b11, 1'b1);
    commit(4'd6, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      check_eq("reject_no_result", xif.result_valid_o, 1'b0);
    end

    // Kill the older entry, complete the younger one (ADD wraps to 0)
    do_issue(4'd1, mk_instr(OPCODE_CUSTOM0, F3_ADD, 5'd2), 1'b1);
    do_issue(4'd2, mk_instr(OPCODE_CUSTOM0, F3_ADD, 5'd3), 1'b1);
    commit(4'd1, 1'b1);
    reg_op(4'd2, 32'hFFFF_FFFF, 32'd1, 2'b11, 1'b1);
    exp_q.push_back({4'd2, 5'd3, 32'd0});
    commit(4'd2, 1'b0);
    drain();

    // Full table
    for (int i = 0; i < 4; i++) do_issue(4'(i), mk_instr(OPCODE_CUSTOM0, F3_ADD, 5'(i + 1)), 1'b1);
    cyc();
    xif.issue_valid_i = 1'b1;
    xif.issue_id_i    = 4'd9;
    xif.issue_instr_i = mk_instr(OPCODE_CUSTOM0, F3_XOR, 5'd9);
    @(negedge clk);
    check_eq("full_issue_ready", xif.issue_ready_o, 1'b0);
    check_eq("full_issue_accept", xif.issue_accept_o, 1'b0);
    reg_op(4'd0, 32'd10, 32'd20, 2'b11, 1'b1);
    exp_q.push_back({4'd0, 5'd1, 32'd30});
    commit(4'd0, 1'b0);
    cyc();
    @(negedge clk);
    check_eq("full_result_valid", xif.result_valid_o, 1'b1);
    check_eq("full_ready_again", xif.issue_ready_o, 1'b1);
    for (int i = 1; i < 4; i++) commit(4'(i), 1'b1);
    drain();

    // Backpressure with two READY entries
    rr_mode = 2;
    do_issue(4'd4, mk_instr(OPCODE_CUSTOM0, F3_ADD, 5'd6), 1'b1);
    do_issue(4'd5, mk_instr(OPCODE_CUSTOM0, F3_XOR, 5'd7), 1'b1);
    reg_op(4'd4, 32'd1, 32'd2, 2'b11, 1'b1);
    reg_op(4'd5, 32'hF0, 32'hFF, 2'b11, 1'b1);
    exp_q.push_back({4'd4, 5'd6, 32'd3});
    exp_q.push_back({4'd5, 5'd7, 32'h0F});
    commit(4'd4, 1'b0);
    commit(4'd5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      check_eq("bp_valid_held", xif.result_valid_o, 1'b1);
      check_eq("bp_id_held", xif.result_id_o, 4'd4);
    end
    cyc();
    rr_mode = 0;
    @(negedge clk);
    check_eq("bp_first_valid", xif.result_valid_o, 1'b1);
    cyc();
    @(negedge clk);
    check_eq("bp_second_valid", xif.result_valid_o, 1'b1);
    check_eq("bp_second_id", xif.result_id_o, 4'd5);
    drain();

    // Reset with three entries in flight
    do_issue(4'd7, mk_instr(OPCODE_CUSTOM0, F3_ADD, 5'd1), 1'b1);
    do_issue(4'd8, mk_instr(OPCODE_CUSTOM0, F3_XOR, 5'd2), 1'b1);
    do_issue(4'd9, mk_instr(OPCODE_CUSTOM0, F3_MAXU, 5'd3), 1'b1);
    reg_op(4'd7, 32'd1, 32'd1, 2'b11, 1'b1);
    reg_op(4'd8, 32'd2, 32'd2, 2'b11, 1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_issue_ready", xif.issue_ready_o, 1'b1);
    check_eq("rst_mid_result_valid", xif.result_valid_o, 1'b0);
    check_eq("rst_mid_head_free", dbg_head_state, FREE);
    reg_op(4'd9, 32'd3, 32'd4, 2'b01, 1'b1);
    commit(4'd7, 1'b0);
    commit(4'd8, 1'b0);
    commit(4'd9, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      check_eq("rst_late_no_result", xif.result_valid_o, 1'b0);
    end
    drain();

    // Randomized rounds
    for (int r = 0; r < 30; r++) begin
      rr_mode = 1;
      n = $urandom_range(1, 4);
      start = $urandom_range(0, 15);
      for (int i = 0; i < n; i++) begin
        r_id[i]  = 4'(start + i);
        r_ins[i] = mk_instr(($urandom_range(0, 5) == 0) ? 7'b0110011 : OPCODE_CUSTOM0,
                            ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)),
                            5'($urandom));
        r_a[i]    = pick_op();
        r_b[i]    = pick_op();
        r_acc[i]  = acc_ref(r_ins[i]);
        r_kill[i] = ($urandom_range(0, 3) == 0);
        r_dead[i] = 1'b0;
        if (r_acc[i] && !r_kill[i])
          exp_q.push_back({r_id[i], r_ins[i][11:7], alu_ref(r_ins[i][14:12], r_a[i], r_b[i])});
      end
      for (int i = 0; i < n; i++) do_issue(r_id[i], r_ins[i], r_acc[i]);
      n2 = 2 * n;
      for (int i = 0; i < n2; i++) act[i] = i;
      for (int i = n2 - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = act[i]; act[i] = act[j]; act[j] = tmp;
      end
      for (int i = 0; i < n2; i++) begin
        e = act[i] / 2;
        if (act[i] % 2 == 0) begin
          if (r_acc[e] && !r_dead[e] && $urandom_range(0, 1) == 1)
            reg_op(r_id[e], r_a[e], r_b[e], ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10, 1'b0);
          reg_op(r_id[e], r_a[e], r_b[e], 2'b11, 1'b1);
        end else begin
          commit(r_id[e], r_kill[e]);
          if (r_kill[e]) r_dead[e] = 1'b1;
        end
      end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xif_copro_tracker.md
Name: xif_copro_tracker

Overview:
- Coprocessor-side endpoint of the CV-X-IF issue, register, commit and result channels. It is the responder to the CPU's offload initiator.
- Accepts custom-0 ALU instructions and tracks them in an in-order table of in-flight IDs.
- Collects source operands and the commit/kill decision for each entry, then returns register writeback results in issue order.
- Instantiated beside a host core on a single hart; the compressed and memory channels are unused.

Parameters:
- X_ID_WIDTH, 4, width of instruction id.
- X_RFR_WIDTH, 32, operand width; also the result data width.
- DEPTH, 4, in-flight table entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- issue_valid_i  in  1  issue request valid.
- issue_ready_o  out  1  ready for an issue request.
- issue_instr_i  in  32  offloaded instruction.
- issue_id_i  in  X_ID_WIDTH  instruction id.
- issue_accept_o  out  1  accept flag.
- issue_writeback_o  out  1  rd writeback will occur.
- issue_register_read_o  out  2  rs1/rs2 needed.
- register_valid_i  in  1  operands valid.
- register_ready_o  out  1  operands consumed.
- register_id_i  in  X_ID_WIDTH  operand id.
- register_rs_i  in  2*X_RFR_WIDTH  rs1 in the low half, rs2 in the high half.
- register_rs_valid_i  in  2  per-operand validity.
- commit_valid_i  in  1  commit strobe.
- commit_id_i  in  X_ID_WIDTH  committed id.
- commit_kill_i  in  1  kill flag.
- result_valid_o  out  1  result valid.
- result_ready_i  in  1  result accepted.
- result_id_o  out  X_ID_WIDTH  result id.
- result_data_o  out  X_RFR_WIDTH  writeback data.
- result_rd_o  out  5  destination register.
- result_we_o  out  1  write enable; always 1 when valid.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset clears all entries and pointers. Every output resets to 0 except issue_ready_o, which is 1.
- Decode (combinational): an instruction is accepted iff opcode = 7'b0001011 and funct3 is in {000 ADD, 001 XOR, 010 MAXU}.
- issue_ready_o = !full. There is no same-cycle pop bypass.
- When issue_valid_i && issue_ready_o:
  - Response is valid in the same cycle.
  - Accept: issue_accept_o=1, issue_writeback_o=1, issue_register_read_o=2'b11. The entry at the tail is written with {id, funct3, rd}, state WAIT.
  - Reject: all response fields are 0 and the table is unchanged.
- Per-entry state machine:
  - FREE -> WAIT on accept.
  - WAIT tracks two flags, ops and cmt. The entry goes READY when both are set.
  - A kill sends the entry to KILLED from any non-FREE state.
  - READY or KILLED -> FREE when the entry pops at the head.
- Register channel:
  - An id lookup runs over non-FREE entries.
  - If found with rs_valid_i=2'b11: register_ready_o=1 and rs1/rs2 are latched, setting ops.
  - If found with partial rs_valid: register_ready_o=0 (wait).
  - If no match: register_ready_o=1 and the data is discarded.
- Commit channel:
  - A matching id with kill=0 sets cmt.
  - kill=1 moves the entry to KILLED.
  - An unmatched commit (e.g. for a rejected instruction) is ignored.
  - Commit and register updates for the same id in the same cycle are both applied; kill has priority.
- Head processing:
  - A KILLED head pops silently, one per cycle.
  - A READY head is computed (ADD = rs1+rs2 mod 2^X_RFR_WIDTH, XOR, MAXU unsigned) into the output register when that register is empty or is being drained this cycle. It then pops.
  - Minimum latency: result_valid_o rises 1 cycle after the head becomes READY.
- Result channel: result_* is held stable while result_valid_o && !result_ready_i. Back-to-back results are sustained at one per cycle.
- Full and empty:
  - When full, issue_ready_o=0.
  - Simultaneous pop and push in one cycle is legal; the count is unchanged.
  - Pointers wrap modulo DEPTH.
- Duplicate in-flight ids are a protocol violation, checked by assertion.
- Reset mid-operation drops all in-flight entries. result_valid_o is 0 in the cycle after reset.

Optional Feature:
- Macro: XIF_COPRO_MUL_EN.
- When defined: funct3=011 (MUL, low X_RFR_WIDTH bits of the unsigned product) is accepted and computed in the head stage.
- When undefined: funct3=011 is rejected.

Decomposition:
- Package xif_copro_pkg holds:
  - OPCODE_CUSTOM0 and the funct3 constants.
  - Entry state enum {FREE, WAIT, READY, KILLED}.
  - Entry struct {id, funct3, rd, rs1, rs2, ops, cmt, state}.
- One sub-module, xif_copro_alu: combinational funct3 + operands -> data.

Test Plan:
- ADD accept: issue id=3, funct3=000, rd=5; register rs1=7, rs2=9; commit kill=0 -> accept=1 in the issue cycle; result id=3, rd=5, data=16 one cycle after the commit.
- Reject: issue opcode 0110011 -> accept=0, writeback=0; a subsequent commit for that id is ignored and no result is produced.
- Kill: issue ids 1 and 2, kill id 1, commit id 2 with operands 0xFFFFFFFF and 1 (ADD) -> a single result, id=2, data=0.
- Full: 4 accepts without commits -> issue_ready_o=0; after the head's commit and result handshake, issue_ready_o=1 the next cycle.
- Backpressure: hold result_ready_i=0 for 3 cycles with 2 READY entries -> outputs stable; then 2 results on consecutive cycles.
- Reset while 3 entries are in flight -> issue_ready_o=1, result_valid_o=0; late commits for the old ids produce no results.
